alarm_bank_reg: RTL and testbench

//  Parametrised multi-slot alarm register bank for the alarm clock. Holds NUM_ALARMS
//  BCD alarm times (HH:MM) with per-slot enables, validates writes, compares against the

---
 rtl/alarm_bank_reg.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alarm_bank_reg.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_bank_reg.sv
// alarm_bank_reg: multi-slot BCD alarm register bank with per-slot enables, write
// validation, minute-tick matching and a ring/stop state machine.
// Optional feature macro: ALARM_SNOOZE_EN adds the SNOOZE state and its minute counter.
module alarm_bank_reg #(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_new_a,
    input  logic [IDX_W-1:0] load_idx,
    input  logic [3:0]       new_alarm_ms_hr,
    input  logic [3:0]       new_alarm_ls_hr,
    input  logic [3:0]       new_alarm_ms_min,
    input  logic [3:0]       new_alarm_ls_min,
    input  logic             alarm_dis,
    input  logic [IDX_W-1:0] read_idx,
    input  logic [3:0]       cur_ms_hr,
    input  logic [3:0]       cur_ls_hr,
    input  logic [3:0]       cur_ms_min,
    input  logic [3:0]       cur_ls_min,
    input  logic             min_tick,
    input  logic             stop_alarm,
    input  logic             snooze,
    output logic [3:0]       alarm_time_ms_hr,
    output logic [3:0]       alarm_time_ls_hr,
    output logic [3:0]       alarm_time_ms_min,
    output logic [3:0]       alarm_time_ls_min,
    output logic             alarm_en_out,
    output logic             load_ack,
    output logic             load_err,
    output logic             alarm_hit,
    output logic [IDX_W-1:0] hit_idx,
    output logic             snoozing
);

    // Slot word layout: {ms_hr, ls_hr, ms_min, ls_min}
`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;
    localparam logic [3:0] SNZ_LOAD = 4'(SNOOZE_MIN);
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1
    } state_t;
`endif

    logic [15:0]           slot_q [NUM_ALARMS];
    logic [15:0]           slot_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q;
    logic [NUM_ALARMS-1:0] en_d;

    logic [15:0]           rd_time_q;
    logic [15:0]           rd_time_d;
    logic                  rd_en_q;
    logic                  rd_en_d;
    logic                  ack_q;
    logic                  ack_d;
    logic                  err_q;
    logic                  err_d;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      hit_idx_q;
    logic [IDX_W-1:0]      hit_idx_d;
    logic                  alarm_hit_q;
    logic                  alarm_hit_d;

    logic [15:0]           new_time;
    logic [15:0]           cur_time;
    logic                  load_idx_ok;
    logic                  read_idx_ok;
    logic                  time_ok;
    logic                  wr_ok;
    logic                  match;
    logic [IDX_W-1:0]      match_idx;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};

    // Write validation: legal 24-hour BCD time into an existing slot
    always_comb begin
        load_idx_ok = (32'(load_idx) < NUM_ALARMS);
        read_idx_ok = (32'(read_idx) < NUM_ALARMS);
        time_ok     = (new_alarm_ms_hr <= 4'd2) &&
                      (new_alarm_ls_hr <= 4'd9) &&
                      ((new_alarm_ms_hr != 4'd2) || (new_alarm_ls_hr <= 4'd3)) &&
                      (new_alarm_ms_min <= 4'd5) &&
                      (new_alarm_ls_min <= 4'd9);
        wr_ok       = load_idx_ok && time_ok;
    end

    // Slot/enable next state; a write strobe takes priority over a disable strobe
    always_comb begin
        slot_d = slot_q;
        en_d   = en_q;
        if (load_new_a) begin
            if (wr_ok) begin
                slot_d[load_idx] = new_time;
                en_d[load_idx]   = 1'b1;
            end
        end else if (alarm_dis && load_idx_ok) begin
            en_d[load_idx] = 1'b0;
        end
    end

    // Read port and write handshake; read samples the already-registered slot contents
    always_comb begin
        rd_time_d = 16'd0;
        rd_en_d   = 1'b0;
        if (read_idx_ok) begin
            rd_time_d = slot_q[read_idx];
            rd_en_d   = en_q[read_idx];
        end
        ack_d = load_new_a && wr_ok;
        err_d = load_new_a && !wr_ok;
    end

    // Priority match: scan downward so the lowest enabled matching slot wins
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (en_q[i] && (slot_q[i] == cur_time)) begin
                match     = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    logic [3:0] snz_cnt_q;
    logic [3:0] snz_cnt_d;
    logic       snoozing_q;
    logic       snoozing_d;

    // Ring/snooze next state; stop always beats snooze
    always_comb begin
        state_d   = state_q;
        hit_idx_d = hit_idx_q;
        snz_cnt_d = snz_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (min_tick && match) begin
                    state_d   = S_RINGING;
                    hit_idx_d = match_idx;
                end
            end
            S_RINGING: begin
                if (stop_alarm) begin
                    state_d = S_IDLE;
                end else if (snooze) begin
                    state_d   = S_SNOOZE;
                    snz_cnt_d = SNZ_LOAD;
                end
            end
            S_SNOOZE: begin
                if (stop_alarm) begin
                    state_d   = S_IDLE;
                    snz_cnt_d = 4'd0;
                end else if (min_tick) begin
                    if (snz_cnt_q <= 4'd1) begin
                        state_d   = S_RINGING;
                        snz_cnt_d = 4'd0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                snz_cnt_d = 4'd0;
            end
        endcase
        alarm_hit_d = (state_d == S_RINGING);
        snoozing_d  = (state_d == S_SNOOZE);
    end

    // FSM registers with registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hit_idx_q   <= '0;
            alarm_hit_q <= 1'b0;
            snz_cnt_q   <= 4'd0;
            snoozing_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_idx_q   <= hit_idx_d;
            alarm_hit_q <= alarm_hit_d;
            snz_cnt_q   <= snz_cnt_d;
            snoozing_q  <= snoozing_d;
        end
    end

    assign snoozing = snoozing_q;
`else
    logic unused_snooze;
    assign unused_snooze = snooze ^ (SNOOZE_MIN != 0);

    // Ring next state without snooze support
    always_comb begin
        state_d   = state_q;
        hit_idx_d = hit_idx_q;
        case (state_q)
            S_IDLE: begin
                if (min_tick && match) begin
                    state_d   = S_RINGING;
                    hit_idx_d = match_idx;
                end
            end
            S_RINGING: begin
                if (stop_alarm) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        alarm_hit_d = (state_d == S_RINGING);
    end

    // FSM registers with registered status output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hit_idx_q   <= '0;
            alarm_hit_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_idx_q   <= hit_idx_d;
            alarm_hit_q <= alarm_hit_d;
        end
    end

    assign snoozing = 1'b0;
`endif

    // Slot storage and enables
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_q[i] <= 16'd0;
            end
            en_q <= '0;
        end else begin
            slot_q <= slot_d;
            en_q   <= en_d;
        end
    end

    // Registered read port and write acknowledge/error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_time_q <= 16'd0;
            rd_en_q   <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_time_q <= rd_time_d;
            rd_en_q   <= rd_en_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign alarm_time_ms_hr  = rd_time_q[15:12];
    assign alarm_time_ls_hr  = rd_time_q[11:8];
    assign alarm_time_ms_min = rd_time_q[7:4];
    assign alarm_time_ls_min = rd_time_q[3:0];
    assign alarm_en_out      = rd_en_q;
    assign load_ack          = ack_q;
    assign load_err          = err_q;
    assign alarm_hit         = alarm_hit_q;
    assign hit_idx           = hit_idx_q;

endmodule

// File: tb/tb_alarm_bank_reg.sv
// tb_alarm_bank_reg: directed and randomized bench for alarm_bank_reg against a
// time-of-day reference model (hours/minutes as integers, ring state as an integer).
module tb_alarm_bank_reg;

    localparam int NA = 4;
    localparam int IW = 2;
    localparam int SM = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_EN = 1'b1;
`else
    localparam bit SNZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_new_a;
    logic [IW-1:0] load_idx;
    logic [3:0]    new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min;
    logic          alarm_dis;
    logic [IW-1:0] read_idx;
    logic [3:0]    cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min;
    logic          min_tick, stop_alarm, snooze;
    logic [3:0]    alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
    logic          alarm_en_out, load_ack, load_err, alarm_hit, snoozing;
    logic [IW-1:0] hit_idx;

    alarm_bank_reg #(.NUM_ALARMS(NA), .IDX_W(IW), .SNOOZE_MIN(SM)) dut (
        .clk(clk), .reset(reset),
        .load_new_a(load_new_a), .load_idx(load_idx),
        .new_alarm_ms_hr(new_alarm_ms_hr), .new_alarm_ls_hr(new_alarm_ls_hr),
        .new_alarm_ms_min(new_alarm_ms_min), .new_alarm_ls_min(new_alarm_ls_min),
        .alarm_dis(alarm_dis), .read_idx(read_idx),
        .cur_ms_hr(cur_ms_hr), .cur_ls_hr(cur_ls_hr),
        .cur_ms_min(cur_ms_min), .cur_ls_min(cur_ls_min),
        .min_tick(min_tick), .stop_alarm(stop_alarm), .snooze(snooze),
        .alarm_time_ms_hr(alarm_time_ms_hr), .alarm_time_ls_hr(alarm_time_ls_hr),
        .alarm_time_ms_min(alarm_time_ms_min), .alarm_time_ls_min(alarm_time_ls_min),
        .alarm_en_out(alarm_en_out), .load_ack(load_ack), .load_err(load_err),
        .alarm_hit(alarm_hit), .hit_idx(hit_idx), .snoozing(snoozing)
    );

    always #5 clk = ~clk;

    // Reference model: alarm times as hour/minute integers
    int m_hr [NA];
    int m_min[NA];
    bit m_en [NA];
    int m_state;   // 0 idle, 1 ringing, 2 snoozing
    int m_hit;
    int m_left;    // minute ticks left in snooze
    int e_hr, e_min;
    bit e_en, e_ack, e_err;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [15:0] bcd_time(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rd_time", {16'd0, alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min},
            {16'd0, bcd_time(e_hr, e_min)});
        chk("rd_en", {31'd0, alarm_en_out}, {31'd0, e_en});
        chk("load_ack", {31'd0, load_ack}, {31'd0, e_ack});
        chk("load_err", {31'd0, load_err}, {31'd0, e_err});
        chk("alarm_hit", {31'd0, alarm_hit}, {31'd0, m_state == 1});
        chk("snoozing", {31'd0, snoozing}, {31'd0, m_state == 2});
        if (m_state != 0) chk("hit_idx", {30'd0, hit_idx}, 32'(m_hit));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NA; i++) begin
            m_hr[i] = 0; m_min[i] = 0; m_en[i] = 1'b0;
        end
        m_state = 0; m_hit = 0; m_left = 0;
        e_hr = 0; e_min = 0; e_en = 1'b0; e_ack = 1'b0; e_err = 1'b0;
    endtask

    task automatic clear_strobes();
        load_new_a = 1'b0; alarm_dis = 1'b0; min_tick = 1'b0;
        stop_alarm = 1'b0; snooze = 1'b0;
    endtask

    // One clock: predict from the current inputs, clock, compare, drop strobes
    task automatic step();
        int ri, li, hr, mn, c_hr, c_min, win;
        bit ok;
        ri    = int'(read_idx);
        e_hr  = m_hr[ri]; e_min = m_min[ri]; e_en = m_en[ri];
        c_hr  = int'(cur_ms_hr) * 10 + int'(cur_ls_hr);
        c_min = int'(cur_ms_min) * 10 + int'(cur_ls_min);
        win = -1;
        for (int i = NA - 1; i >= 0; i--)
            if (m_en[i] && m_hr[i] == c_hr && m_min[i] == c_min) win = i;
        e_ack = 1'b0; e_err = 1'b0;
        li = int'(load_idx);
        if (load_new_a) begin
            hr = int'(new_alarm_ms_hr) * 10 + int'(new_alarm_ls_hr);
            mn = int'(new_alarm_ms_min) * 10 + int'(new_alarm_ls_min);
            ok = (li < NA) && new_alarm_ls_hr <= 9 && new_alarm_ls_min <= 9 &&
                 new_alarm_ms_min <= 5 && hr <= 23;
            if (ok) begin
                m_hr[li] = hr; m_min[li] = mn; m_en[li] = 1'b1; e_ack = 1'b1;
            end else begin
                e_err = 1'b1;
            end
        end else if (alarm_dis && li < NA) begin
            m_en[li] = 1'b0;
        end
        if (m_state == 0) begin
            if (min_tick && win >= 0) begin m_state = 1; m_hit = win; end
        end else if (m_state == 1) begin
            if (stop_alarm) m_state = 0;
            else if (snooze && SNZ_EN) begin m_state = 2; m_left = SM; end
        end else begin
            if (stop_alarm) m_state = 0;
            else if (min_tick) begin
                m_left = m_left - 1;
                if (m_left == 0) m_state = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
        clear_strobes();
    endtask

    task automatic set_load(input int idx, input int a, input int b, input int c, input int d);
        load_new_a = 1'b1; load_idx = IW'(idx);
        new_alarm_ms_hr = 4'(a); new_alarm_ls_hr = 4'(b);
        new_alarm_ms_min = 4'(c); new_alarm_ls_min = 4'(d);
    endtask

    task automatic set_cur(input int h, input int m);
        cur_ms_hr = 4'(h / 10); cur_ls_hr = 4'(h % 10);
        cur_ms_min = 4'(m / 10); cur_ls_min = 4'(m % 10);
    endtask

    initial begin
        reset = 1'b1;
        clear_strobes();
        load_idx = '0; read_idx = '0;
        new_alarm_ms_hr = 4'd0; new_alarm_ls_hr = 4'd0;
        new_alarm_ms_min = 4'd0; new_alarm_ls_min = 4'd0;
        set_cur(0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Load slot 2 = 07:30, then read it back
        read_idx = 2'd2;
        set_load(2, 0, 7, 3, 0); step();
        step();
        step();

        // Illegal writes to slot 1 leave it untouched
        read_idx = 2'd1;
        set_load(1, 2, 4, 0, 0); step();
        set_load(1, 1, 2, 6, 0); step();
        step();

        // Slots 0 and 3 at 06:45, match picks slot 0, then stop
        set_load(0, 0, 6, 4, 5); step();
        set_load(3, 0, 6, 4, 5); step();
        set_cur(6, 45);
        min_tick = 1'b1; step();
        stop_alarm = 1'b1; step();

        // Disable slot 0: match picks slot 3; further matches while ringing ignored
        alarm_dis = 1'b1; load_idx = 2'd0; step();
        min_tick = 1'b1; step();
        min_tick = 1'b1; step();
        alarm_dis = 1'b1; load_idx = 2'd3; step();
        set_load(0, 0, 6, 4, 5); alarm_dis = 1'b1; step();
        read_idx = 2'd0; step();
        step();

        // Snooze (or ignored snooze when the feature is absent)
        snooze = 1'b1; step();
        min_tick = 1'b1; step();
        min_tick = 1'b1; step();
        snooze = 1'b1; step();
        snooze = 1'b1; stop_alarm = 1'b1; step();
        min_tick = 1'b1; step();
        snooze = 1'b1; stop_alarm = 1'b1; step();

        // Reset while ringing, with a valid write strobe held
        min_tick = 1'b1; step();
        set_load(1, 1, 1, 1, 1);
        reset = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;
        clear_strobes();
        for (int i = 0; i < NA; i++) begin
            read_idx = IW'(i); step();
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int k;
            load_new_a = ($urandom % 100) < 25;
            load_idx = IW'($urandom);
            new_alarm_ms_hr  = 4'($urandom_range(0, 3));
            new_alarm_ls_hr  = 4'($urandom_range(0, 11));
            new_alarm_ms_min = 4'($urandom_range(0, 6));
            new_alarm_ls_min = 4'($urandom_range(0, 10));
            alarm_dis  = ($urandom % 100) < 10;
            read_idx   = IW'($urandom);
            k = $urandom_range(0, NA - 1);
            if ($urandom % 2 == 0) set_cur(m_hr[k], m_min[k]);
            else set_cur($urandom_range(0, 23), $urandom_range(0, 59));
            min_tick   = ($urandom % 100) < 30;
            stop_alarm = ($urandom % 100) < 10;
            snooze     = ($urandom % 100) < 15;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
